bcd2bin_serial_ctrl: RTL and testbench
======================================

BCD2BIN_SERIAL_CTRL -- requirements
Module: bcd2bin_serial_ctrl

Interface
REQ-001 Parameter DIGITS, default 3: number of packed BCD digits per conversion, most significant digit in the top nibble.
REQ-002 Parameter BIN_W, default 10: result width; SHALL satisfy 2^BIN_W > 10^DIGITS - 1.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 in_valid  input  1  request: bcd_in holds a value to convert.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 bcd_in  input  4*DIGITS  packed BCD operand.
REQ-008 out_valid  output  1  binary/err hold a completed result.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 binary  output  BIN_W  converted value; registered.
REQ-011 err  output  1  at least one input nibble was greater than 9; registered.
REQ-012 busy  output  1  high in CONV or DONE.

Function
REQ-013 FSM states SHALL be IDLE, CONV and DONE; reset state is IDLE.
REQ-014 IDLE: in_ready=1, out_valid=0, busy=0.
- Accept when in_valid && in_ready.
- On acceptance: capture bcd_in into the shift register, clear the accumulator, err_flag and digit counter, then go to CONV.
REQ-015 bcd_in SHALL be sampled only on the acceptance edge; later changes have no effect on the result.
REQ-016 CONV: one digit per clock, MSD first.
- acc <= acc*10 + d, where acc*10 = (acc<<3)+(acc<<1) is computed in BIN_W+4 bits and truncated to BIN_W.
- Shift register moves left by 4 each clock.
- The counter increments each clock.
REQ-017 In CONV, a digit d > 9 SHALL set err_flag (sticky for that conversion); d is still added to acc.
REQ-018 After the DIGITS-th CONV clock, the FSM SHALL go to DONE.
- binary <= err_flag ? 0 : acc.
- err <= err_flag (include the current digit's check).
REQ-019 Latency: out_valid SHALL rise exactly DIGITS+1 rising edges after the acceptance edge.
- Default DIGITS=3: accept at edge E0, out_valid high after edge E4.
REQ-020 DONE: out_valid=1, in_ready=0.
- binary and err SHALL stay stable until out_valid && out_ready.
- After that handshake, the next state is IDLE.
REQ-021 in_ready SHALL be 0 in CONV and DONE.
- in_valid is ignored there; the request is not queued.
- Minimum request-to-request period is DIGITS+3 clocks with out_ready tied high.
REQ-022 binary and err SHALL retain the last result in IDLE until the next DONE update; out_valid SHALL be 0 outside DONE.
REQ-023 No combinational path from in_valid or out_ready to any output; all outputs are decoded from registers or the state.

Reset
REQ-024 With rst high at a rising edge, after that edge:
- state=IDLE, in_ready=1, out_valid=0, busy=0;
- binary=0, err=0, accumulator=0, counter=0.
REQ-025 Reset SHALL take priority over any handshake in the same cycle.
REQ-026 Reset during CONV or DONE SHALL abort the conversion with no result output.

Verification
REQ-027 Basic conversion: bcd_in=12'h123 accepted, out_ready=1 -> out_valid exactly 4 edges after acceptance, binary=123 (10'h07B), err=0, out_valid high exactly 1 cycle.
REQ-028 Bounds: 12'h999 -> binary=999 (10'h3E7), err=0; 12'h000 -> binary=0, err=0.
REQ-029 Invalid digit: 12'h1A5 -> err=1, binary=0; next request 12'h205 -> err=0, binary=205.
REQ-030 Back-pressure: out_ready low for 5 cycles after out_valid -> binary/err constant, in_ready=0, in_valid with 12'h777 ignored; out_ready high -> IDLE next edge, no 777 result ever produced.
REQ-031 Reset mid-operation: rst pulsed 1 cycle during second CONV clock of 12'h456 -> next cycle IDLE, in_ready=1, out_valid=0, binary=0, err=0; then 12'h042 -> binary=42.
REQ-032 Input hold: bcd_in changed every cycle after acceptance of 12'h318 -> result binary=318.

Source files
------------

// File: rtl/bcd2bin_serial_ctrl.sv
// Serial packed-BCD to binary converter: one digit per clock, MSD first,
// with a valid/ready request side and a valid/ready result side.
module bcd2bin_serial_ctrl #(
    parameter int unsigned DIGITS = 3,
    parameter int unsigned BIN_W  = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BIN_W-1:0]      binary,
    output logic                  err,
    output logic                  busy
);

    localparam int unsigned CW = $clog2(DIGITS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [4*DIGITS-1:0]   sr_q, sr_d;
    logic [BIN_W-1:0]      acc_q, acc_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  err_flag_q, err_flag_d;
    logic [BIN_W-1:0]      binary_q, binary_d;
    logic                  err_q, err_d;

    logic [3:0]            digit;
    logic [BIN_W+3:0]      acc_x10;

    assign digit   = sr_q[4*DIGITS-1 -: 4];
    assign acc_x10 = ({4'b0000, acc_q} << 3) + ({4'b0000, acc_q} << 1);

    always_comb begin
        state_d    = state_q;
        sr_d       = sr_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        err_flag_d = err_flag_q;
        binary_d   = binary_q;
        err_d      = err_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    sr_d       = bcd_in;
                    acc_d      = '0;
                    cnt_d      = '0;
                    err_flag_d = 1'b0;
                    state_d    = CONV;
                end
            end
            CONV: begin
                // DIGITS digit clocks followed by one result-writeback clock.
                if (cnt_q == CW'(DIGITS)) begin
                    binary_d = err_flag_q ? '0 : acc_q;
                    err_d    = err_flag_q;
                    state_d  = DONE;
                end else begin
                    acc_d      = acc_x10[BIN_W-1:0] + BIN_W'(digit);
                    sr_d       = sr_q << 4;
                    cnt_d      = cnt_q + 1'b1;
                    err_flag_d = err_flag_q | (digit > 4'd9);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sr_q       <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            err_flag_q <= 1'b0;
            binary_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            err_flag_q <= err_flag_d;
            binary_q   <= binary_d;
            err_q      <= err_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign binary    = binary_q;
    assign err       = err_q;

endmodule

// File: tb/tb_bcd2bin_serial_ctrl.sv
// Directed bench for bcd2bin_serial_ctrl: latency, bounds, invalid digits,
// back-pressure, mid-conversion reset and input-hold behaviour.
module tb_bcd2bin_serial_ctrl;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] bcd_in;
    logic        out_valid;
    logic        out_ready;
    logic [9:0]  binary;
    logic        err;
    logic        busy;

    int vectors;
    int miscompares;

    bcd2bin_serial_ctrl #(.DIGITS(3), .BIN_W(10)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bcd_in    (bcd_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .binary    (binary),
        .err       (err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Accept one request, check exact latency and the result, then handshake.
    task automatic convert(input logic [11:0] bcd, input logic [9:0] exp_bin,
                           input logic exp_err, input bit scramble);
        check("pre_in_ready", in_ready, 1'b1);
        in_valid  = 1'b1;
        bcd_in    = bcd;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("accept_busy", busy, 1'b1);
        check("accept_in_ready", in_ready, 1'b0);
        for (int i = 0; i < 4; i++) begin
            check("latency_out_valid_low", out_valid, 1'b0);
            if (scramble) bcd_in = 12'($urandom);
            tick();
        end
        check("done_out_valid", out_valid, 1'b1);
        check("done_binary", binary, exp_bin);
        check("done_err", err, exp_err);
        tick();
        check("post_out_valid", out_valid, 1'b0);
        check("post_in_ready", in_ready, 1'b1);
        check("post_busy", busy, 1'b0);
        check("retain_binary", binary, exp_bin);
        check("retain_err", err, exp_err);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        bcd_in      = '0;
        out_ready   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_binary", binary, 10'd0);
        check("rst_err", err, 1'b0);

        convert(12'h123, 10'h07B, 1'b0, 1'b0);
        convert(12'h999, 10'h3E7, 1'b0, 1'b0);
        convert(12'h000, 10'h000, 1'b0, 1'b0);
        convert(12'h1A5, 10'h000, 1'b1, 1'b0);
        convert(12'h205, 10'h0CD, 1'b0, 1'b0);
        convert(12'h318, 10'h13E, 1'b0, 1'b1);

        // Back-pressure: hold result while a 777 request is offered.
        in_valid  = 1'b1;
        bcd_in    = 12'h654;
        out_ready = 1'b0;
        tick();
        bcd_in = 12'h777;
        for (int i = 0; i < 4; i++) tick();
        check("bp_out_valid", out_valid, 1'b1);
        check("bp_binary", binary, 10'h28E);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_valid", out_valid, 1'b1);
            check("bp_hold_binary", binary, 10'h28E);
            check("bp_hold_err", err, 1'b0);
            check("bp_hold_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        tick();
        check("bp_release_idle", in_ready, 1'b1);
        check("bp_release_valid", out_valid, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check("bp_no_777_valid", out_valid, 1'b0);
            check("bp_no_777_binary", binary, 10'h28E);
        end

        // Reset on the second CONV clock aborts the conversion.
        in_valid = 1'b1;
        bcd_in   = 12'h456;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_in_ready", in_ready, 1'b1);
        check("abort_out_valid", out_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_binary", binary, 10'd0);
        check("abort_err", err, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("abort_no_result", out_valid, 1'b0);
        end
        convert(12'h042, 10'h02A, 1'b0, 1'b0);

        // Reset wins over an acceptance in the same cycle.
        in_valid = 1'b1;
        bcd_in   = 12'h111;
        rst      = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        check("rst_prio_in_ready", in_ready, 1'b1);
        check("rst_prio_busy", busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
